// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with an iterative multiplier and an optional divider.
//
// Holds one operation at a time. Single-cycle ops finish one cycle after they are
// accepted. MUL/MULHU use shift-add and finish WIDTH+1 cycles after acceptance.
// DIVU/REMU use restoring division and also finish WIDTH+1 cycles after acceptance.
//
// Optional feature macro: SEQ_ALU_DIV_EN.
//   Defined   : divider datapath and DIV state are built.
//   Undefined : opcodes 1100/1101 report err like any illegal opcode.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    operation request
//   in_ready    block can accept a request this cycle
//   a, b        operands (WIDTH bits), sampled only at acceptance
//   alucontrol  4-bit opcode
//   out_valid   result/flags/err valid
//   out_ready   consumer takes the result this cycle
//   result      registered result (WIDTH bits)
//   flags       registered {v,c,n,z}
//   err         illegal opcode, qualified by out_valid
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alucontrol,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             err
);

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_SLT   = 4'b0101;
   localparam logic [3:0] OP_SLL   = 4'b0110;
   localparam logic [3:0] OP_SRL   = 4'b0111;
   localparam logic [3:0] OP_SRA   = 4'b1000;
   localparam logic [3:0] OP_SLTU  = 4'b1001;
   localparam logic [3:0] OP_MUL   = 4'b1010;
   localparam logic [3:0] OP_MULHU = 4'b1011;
`ifdef SEQ_ALU_DIV_EN
   localparam logic [3:0] OP_DIVU  = 4'b1100;
   localparam logic [3:0] OP_REMU  = 4'b1101;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
`ifdef SEQ_ALU_DIV_EN
      DIV  = 2'd2,
`endif
      DONE = 2'd3
   } stateType;

   stateType         state, nextState;
   logic [SHW-1:0]   counter;
   logic [WIDTH-1:0] accHi, accLo, operandReg;
   logic             pickHigh;
   logic             accept, iterating;

   logic             useSub, carry, overflow;
   logic [WIDTH-1:0] bOperand, sum;
   logic [WIDTH-1:0] aluResult;
   logic             aluV, aluC, aluErr, startMul, startDiv;

   logic [WIDTH:0]   mulSum;
   logic [WIDTH-1:0] iterHi, iterLo, finalResult;
`ifdef SEQ_ALU_DIV_EN
   logic [WIDTH:0]   divTrial;
`endif

   // Handshake: a new op can be taken when idle, or when the finished result
   // is being consumed in the same cycle (back-to-back issue).
   always_comb begin
      in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
      accept    = in_valid && in_ready;
      out_valid = (state == DONE);
`ifdef SEQ_ALU_DIV_EN
      iterating = (state == MUL) || (state == DIV);
`else
      iterating = (state == MUL);
`endif
   end

   // Single-cycle datapath. Add, sub, slt and sltu share one adder: subtraction
   // is a + ~b + 1, so slt and sltu fall out of the sign/overflow and carry.
   // Multi-cycle opcodes only raise a start request here.
   always_comb begin
      useSub    = (alucontrol == OP_SUB) || (alucontrol == OP_SLT) || (alucontrol == OP_SLTU);
      bOperand  = useSub ? ~b : b;
      {carry, sum} = {1'b0, a} + {1'b0, bOperand} + (WIDTH+1)'(useSub);
      overflow  = ~(useSub ^ a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
      aluResult = '0;
      aluV      = 1'b0;
      aluC      = 1'b0;
      aluErr    = 1'b0;
      startMul  = 1'b0;
      startDiv  = 1'b0;
      case (alucontrol)
         OP_ADD, OP_SUB: begin
            aluResult = sum;
            aluV      = overflow;
            aluC      = carry;
         end
         OP_AND: aluResult = a & b;
         OP_OR:  aluResult = a | b;
         OP_XOR: aluResult = a ^ b;
         OP_SLT: begin
            aluResult = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ overflow};
            aluV      = overflow;
            aluC      = carry;
         end
         OP_SLTU: begin
            aluResult = {{(WIDTH-1){1'b0}}, ~carry};
            aluV      = overflow;
            aluC      = carry;
         end
         OP_SLL: aluResult = a << b[SHW-1:0];
         OP_SRL: aluResult = a >> b[SHW-1:0];
         OP_SRA: aluResult = $signed(a) >>> b[SHW-1:0];
         OP_MUL, OP_MULHU: startMul = 1'b1;
`ifdef SEQ_ALU_DIV_EN
         OP_DIVU, OP_REMU: begin
            if (b == '0) begin
               aluResult = (alucontrol == OP_DIVU) ? '1 : a;
            end else begin
               startDiv = 1'b1;
            end
         end
`endif
         default: aluErr = 1'b1;
      endcase
   end

   // One iteration step. Multiply: accLo holds the remaining multiplier bits and
   // receives product low bits as they shift out of accHi. Divide: accHi is the
   // partial remainder, accLo shifts dividend bits out and quotient bits in.
   // finalResult picks the high or low half of the step about to be written.
   always_comb begin
      mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, operandReg} : '0);
      iterHi = mulSum[WIDTH:1];
      iterLo = {mulSum[0], accLo[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
      divTrial = {accHi, accLo[WIDTH-1]} - {1'b0, operandReg};
      if (state == DIV) begin
         iterHi = divTrial[WIDTH] ? {accHi[WIDTH-2:0], accLo[WIDTH-1]} : divTrial[WIDTH-1:0];
         iterLo = {accLo[WIDTH-2:0], ~divTrial[WIDTH]};
      end
`endif
      finalResult = pickHigh ? iterHi : iterLo;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. IDLE and DONE share the accept path so back-to-back ops
   // take exactly the same transitions as ops issued from IDLE.
   always_comb begin
      nextState = state;
      case (state)
         IDLE, DONE: begin
            if (accept) begin
               if (startMul) begin
                  nextState = MUL;
`ifdef SEQ_ALU_DIV_EN
               end else if (startDiv) begin
                  nextState = DIV;
`endif
               end else begin
                  nextState = DONE;
               end
            end else if ((state == DONE) && out_ready) begin
               nextState = IDLE;
            end
         end
         MUL: if (counter == '0) nextState = DONE;
`ifdef SEQ_ALU_DIV_EN
         DIV: if (counter == '0) nextState = DONE;
`endif
         default: nextState = IDLE;
      endcase
   end

   // Datapath registers. Single-cycle results land at the acceptance edge;
   // iterative ops load their operands there and write the result on the
   // edge where the counter reaches zero. Outputs are only written at those
   // points, so they hold while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result     <= '0;
         flags      <= '0;
         err        <= 1'b0;
         counter    <= '0;
         accHi      <= '0;
         accLo      <= '0;
         operandReg <= '0;
         pickHigh   <= 1'b0;
      end else if (accept) begin
         if (startMul) begin
            accHi      <= '0;
            accLo      <= b;
            operandReg <= a;
            counter    <= SHW'(WIDTH-1);
            pickHigh   <= (alucontrol == OP_MULHU);
`ifdef SEQ_ALU_DIV_EN
         end else if (startDiv) begin
            accHi      <= '0;
            accLo      <= a;
            operandReg <= b;
            counter    <= SHW'(WIDTH-1);
            pickHigh   <= (alucontrol == OP_REMU);
`endif
         end else begin
            result <= aluResult;
            flags  <= aluErr ? 4'b0000 : {aluV, aluC, aluResult[WIDTH-1], aluResult == '0};
            err    <= aluErr;
         end
      end else if (iterating) begin
         accHi   <= iterHi;
         accLo   <= iterLo;
         counter <= counter - SHW'(1);
         if (counter == '0) begin
            result <= finalResult;
            flags  <= {2'b00, finalResult[WIDTH-1], finalResult == '0};
            err    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: self-checking bench for seq_alu (WIDTH=32).
//
// A table of directed vectors with hand-computed results, flags, err and
// latency is run through the DUT one op at a time. Hand-written sequences then
// cover output hold under back-pressure, back-to-back issue and reset during a
// multiply. Expectations for DIVU/REMU follow SEQ_ALU_DIV_EN.
module tb_seq_alu;

   localparam int WIDTH = 32;
`ifdef SEQ_ALU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_SLT   = 4'b0101;
   localparam logic [3:0] OP_SLL   = 4'b0110;
   localparam logic [3:0] OP_SRL   = 4'b0111;
   localparam logic [3:0] OP_SRA   = 4'b1000;
   localparam logic [3:0] OP_SLTU  = 4'b1001;
   localparam logic [3:0] OP_MUL   = 4'b1010;
   localparam logic [3:0] OP_MULHU = 4'b1011;
   localparam logic [3:0] OP_DIVU  = 4'b1100;
   localparam logic [3:0] OP_REMU  = 4'b1101;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       alucontrol;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [3:0]       flags;
   logic             err;

   int passCount  = 0;
   int checkCount = 0;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] va;
      logic [31:0] vb;
      logic [31:0] expResult;
      logic [3:0]  expFlags;
      logic        expErr;
      int          expLatency;
   } vecT;

   vecT vecs[$];

   seq_alu #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .alucontrol (alucontrol),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .flags      (flags),
      .err        (err)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case anything stalls beyond every per-wait bound.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   function automatic vecT mkVec(string n, logic [3:0] op, logic [31:0] va, logic [31:0] vb,
                                 logic [31:0] r, logic [3:0] f, logic e, int lat);
      vecT v;
      v.name = n; v.op = op; v.va = va; v.vb = vb;
      v.expResult = r; v.expFlags = f; v.expErr = e; v.expLatency = lat;
      return v;
   endfunction

   // Divider ops are illegal (err, zero result, latency 1) when the divider is absent.
   function automatic vecT divVec(string n, logic [3:0] op, logic [31:0] va, logic [31:0] vb,
                                  logic [31:0] r, logic [3:0] f, int lat);
      if (DIV_EN) return mkVec(n, op, va, vb, r, f, 1'b0, lat);
      return mkVec(n, op, va, vb, 32'h0, 4'h0, 1'b1, 1);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end else begin
         passCount++;
      end
   endtask

   // Issues one op from IDLE (called at a negedge), scrambles the operands after
   // acceptance, then counts negedges until out_valid. Leaves the bench at the
   // negedge where out_valid was first seen (or where the bound ran out).
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                                output int latency, output bit readyLeak);
      in_valid   = 1'b1;
      alucontrol = op;
      a          = va;
      b          = vb;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      latency  = 0;
      readyLeak = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         latency++;
         if (out_valid) break;
         if (in_ready) readyLeak = 1'b1;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      int  latency;
      bit  readyLeak;
      bit  sawValid;

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      a          = '0;
      b          = '0;
      alucontrol = '0;

      vecs.push_back(mkVec("add_ovf",     OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1010, 1'b0, 1));
      vecs.push_back(mkVec("add_carry",   OP_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0101, 1'b0, 1));
      vecs.push_back(mkVec("sub_eq",      OP_SUB,   32'h00000005, 32'h00000005, 32'h00000000, 4'b0101, 1'b0, 1));
      vecs.push_back(mkVec("sub_neg",     OP_SUB,   32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0010, 1'b0, 1));
      vecs.push_back(mkVec("and",         OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0010, 1'b0, 1));
      vecs.push_back(mkVec("or",          OP_OR,    32'h0000000F, 32'h000000F0, 32'h000000FF, 4'b0000, 1'b0, 1));
      vecs.push_back(mkVec("xor",         OP_XOR,   32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 4'b0001, 1'b0, 1));
      vecs.push_back(mkVec("slt_ovf",     OP_SLT,   32'h80000000, 32'h00000001, 32'h00000001, 4'b1100, 1'b0, 1));
      vecs.push_back(mkVec("slt",         OP_SLT,   32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4'b0001, 1'b0, 1));
      vecs.push_back(mkVec("sltu",        OP_SLTU,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 1'b0, 1));
      vecs.push_back(mkVec("sll",         OP_SLL,   32'h00000001, 32'h0000003F, 32'h80000000, 4'b0010, 1'b0, 1));
      vecs.push_back(mkVec("srl",         OP_SRL,   32'h80000000, 32'h00000004, 32'h08000000, 4'b0000, 1'b0, 1));
      vecs.push_back(mkVec("sra",         OP_SRA,   32'h80000000, 32'h00000024, 32'hF8000000, 4'b0010, 1'b0, 1));
      vecs.push_back(mkVec("mul_max",     OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 1'b0, 33));
      vecs.push_back(mkVec("mulhu_max",   OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0010, 1'b0, 33));
      vecs.push_back(mkVec("mul_wrap",    OP_MUL,   32'h00010000, 32'h00010000, 32'h00000000, 4'b0001, 1'b0, 33));
      vecs.push_back(mkVec("mulhu_wrap",  OP_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, 4'b0000, 1'b0, 33));
      vecs.push_back(divVec("divu",       OP_DIVU,  32'd100,      32'd7,        32'd14,       4'b0000, 33));
      vecs.push_back(divVec("remu",       OP_REMU,  32'd100,      32'd7,        32'd2,        4'b0000, 33));
      vecs.push_back(divVec("divu_by1",   OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 4'b0010, 33));
      vecs.push_back(divVec("remu_small", OP_REMU,  32'd7,        32'd10,       32'd7,        4'b0000, 33));
      vecs.push_back(divVec("divu_zero",  OP_DIVU,  32'd9,        32'd0,        32'hFFFFFFFF, 4'b0010, 1));
      vecs.push_back(divVec("remu_zero",  OP_REMU,  32'd9,        32'd0,        32'd9,        4'b0000, 1));
      vecs.push_back(mkVec("illegal_e",   4'b1110,  32'h00000003, 32'h00000004, 32'h00000000, 4'b0000, 1'b1, 1));
      vecs.push_back(mkVec("illegal_f",   4'b1111,  32'h00000003, 32'h00000004, 32'h00000000, 4'b0000, 1'b1, 1));

      // Reset state, checked while rst_n is still low.
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset.out_valid", 64'(out_valid), 64'(0));
      checkOutput("reset.result",    64'(result),    64'(0));
      checkOutput("reset.flags",     64'(flags),     64'(0));
      checkOutput("reset.err",       64'(err),       64'(0));
      checkOutput("reset.in_ready",  64'(in_ready),  64'(1));
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors.
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].va, vecs[i].vb, latency, readyLeak);
         checkOutput({vecs[i].name, ".latency"},   64'(latency),   64'(vecs[i].expLatency));
         checkOutput({vecs[i].name, ".out_valid"}, 64'(out_valid), 64'(1));
         checkOutput({vecs[i].name, ".result"},    64'(result),    64'(vecs[i].expResult));
         checkOutput({vecs[i].name, ".flags"},     64'(flags),     64'(vecs[i].expFlags));
         checkOutput({vecs[i].name, ".err"},       64'(err),       64'(vecs[i].expErr));
         checkOutput({vecs[i].name, ".busy_ready"}, 64'(readyLeak), 64'(0));
         consume();
      end

      // Back-pressure: result must hold and no new request may be taken.
      applyStimulus(OP_ADD, 32'd2, 32'd3, latency, readyLeak);
      checkOutput("hold.latency", 64'(latency), 64'(1));
      in_valid   = 1'b1;
      alucontrol = OP_SUB;
      a          = 32'd1;
      b          = 32'd2;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput($sformatf("hold%0d.out_valid", c), 64'(out_valid), 64'(1));
         checkOutput($sformatf("hold%0d.result", c),    64'(result),    64'(5));
         checkOutput($sformatf("hold%0d.in_ready", c),  64'(in_ready),  64'(0));
      end

      // Back-to-back: consume and issue the pending sub on the same edge.
      out_ready = 1'b1;
      #1;
      checkOutput("b2b.in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      checkOutput("b2b.out_valid", 64'(out_valid), 64'(1));
      checkOutput("b2b.result",    64'(result),    64'hFFFFFFFF);
      checkOutput("b2b.flags",     64'(flags),     64'(4'b0010));
      consume();

      // Reset during a multiply: outputs clear at once, the op is discarded.
      in_valid   = 1'b1;
      alucontrol = OP_MUL;
      a          = 32'd3;
      b          = 32'd5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      checkOutput("midmul.out_valid", 64'(out_valid), 64'(0));
      checkOutput("midmul.in_ready",  64'(in_ready),  64'(0));
      checkOutput("midmul.result",    64'(result),    64'hFFFFFFFF);
      rst_n = 1'b0;
      #1;
      checkOutput("rstmul.out_valid", 64'(out_valid), 64'(0));
      checkOutput("rstmul.result",    64'(result),    64'(0));
      checkOutput("rstmul.flags",     64'(flags),     64'(0));
      checkOutput("rstmul.in_ready",  64'(in_ready),  64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      sawValid = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (out_valid) sawValid = 1'b1;
      end
      checkOutput("rstmul.discarded", 64'(sawValid), 64'(0));

      // Recovery after reset.
      applyStimulus(OP_MUL, 32'd3, 32'd5, latency, readyLeak);
      checkOutput("recover.latency", 64'(latency), 64'(33));
      checkOutput("recover.result",  64'(result),  64'(15));
      consume();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
